rs_stream_decoder: RTL

- Symbol-serial, parametrised single-symbol-error Reed-Solomon decoder with valid/ready streaming on both sides.
- Accepts one N-symbol codeword, one symbol per beat, into an internal buffer while accumulating syndromes S1/S2 by Horner's rule. It then solves for the error locator X = S2/S1 and the error value Y = S1²/S2, and streams the corrected codeword out.
- Successor to the combinational RS decoder: adds generic GF width and length, backpressure, and per-codeword status flags (corrected / uncorrectable).
- Sits between the channel deserialiser and the payload consumer.

---
 rtl/rs_stream_decoder_pkg.sv | 82 ++++++++
 rtl/rs_stream_decoder_if.sv | 28 ++
 rtl/rs_stream_decoder_syndrome_acc.sv | 54 +++++
 rtl/rs_stream_decoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rs_stream_decoder_pkg.sv
// Shared types, default parameters and GF(2^m) helpers for the RS stream decoder.
// Field elements are carried in a fixed-width container (gf_t); the field width m
// is passed explicitly, so any m from 2 to 15 is supported.
package rs_stream_decoder_pkg;

   localparam int unsigned DEF_SYMBOL_WIDTH = 4;
   localparam int unsigned DEF_N            = 15;
   localparam logic [4:0]  DEF_GF_POLY      = 5'b10011;
   localparam int unsigned DEF_CNT_WIDTH    = 16;
   localparam int unsigned GF_MAXW          = 16;

   typedef logic [GF_MAXW-1:0] gf_t;

   typedef enum logic [1:0] {IDLE, COLLECT, SOLVE, EMIT} state_t;
   typedef enum logic [1:0] {CLEAN, CANDIDATE, UNCORR} synd_class_t;

   // a * alpha: shift left, fold the polynomial back in when the old MSB was set
   function automatic gf_t gf_mul_alpha(input gf_t a, input gf_t poly, input int unsigned m);
      if (((a >> (m - 1)) & gf_t'(1)) != '0)
         return (a << 1) ^ poly;
      else
         return a << 1;
   endfunction

   // a * alpha^-1: fold the polynomial in when the LSB is set, then shift right
   function automatic gf_t gf_mul_alpha_inv(input gf_t a, input gf_t poly, input int unsigned m);
      if (m == 0)
         return '0;
      if (a[0])
         return (a ^ poly) >> 1;
      else
         return a >> 1;
   endfunction

   // Shift-and-add multiply, LSB of b first
   function automatic gf_t gf_mul(input gf_t a, input gf_t b, input gf_t poly, input int unsigned m);
      gf_t r;
      gf_t aa;
      gf_t bb;
      r  = '0;
      aa = a;
      bb = b;
      for (int unsigned i = 0; i < GF_MAXW; i++) begin
         if (i < m) begin
            if (bb[0])
               r = r ^ aa;
            aa = gf_mul_alpha(aa, poly, m);
            bb = bb >> 1;
         end
      end
      return r;
   endfunction

   // a^-1 = a^(2^m - 2) = product of a^(2^i) for i = 1 .. m-1; inverse of 0 yields 0
   function automatic gf_t gf_inv(input gf_t a, input gf_t poly, input int unsigned m);
      gf_t sq;
      gf_t r;
      sq = a;
      r  = gf_t'(1);
      for (int unsigned i = 1; i < GF_MAXW; i++) begin
         if (i < m) begin
            sq = gf_mul(sq, sq, poly, m);
            r  = gf_mul(r, sq, poly, m);
         end
      end
      return r;
   endfunction

   function automatic gf_t gf_div(input gf_t a, input gf_t b, input gf_t poly, input int unsigned m);
      return gf_mul(a, gf_inv(b, poly, m), poly, m);
   endfunction

   // alpha^n, used for elaboration-time constants only
   function automatic gf_t gf_alpha_pow(input int unsigned n, input gf_t poly, input int unsigned m);
      gf_t r;
      r = gf_t'(1);
      for (int unsigned i = 0; i < n; i++)
         r = gf_mul_alpha(r, poly, m);
      return r;
   endfunction

endpackage

// File: rtl/rs_stream_decoder_if.sv
// Input and output valid/ready symbol streams of the RS decoder.
interface rs_stream_decoder_if #(
   parameter int unsigned SYMBOL_WIDTH = 4
) ();

   logic                    in_valid;
   logic                    in_ready;
   logic [SYMBOL_WIDTH-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SYMBOL_WIDTH-1:0] out_data;
   logic                    out_last;
   logic                    out_corrected;
   logic                    out_uncorrectable;

   // Producer / consumer side
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_corrected, out_uncorrectable
   );

   // Decoder side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, out_corrected, out_uncorrectable
   );

endinterface

// File: rtl/rs_stream_decoder_syndrome_acc.sv
// Horner accumulators for S1 = r(alpha) and S2 = r(alpha^2), one symbol per enable.
module rs_syndrome_acc
   import rs_stream_decoder_pkg::*;
#(
   parameter int unsigned           SYMBOL_WIDTH = DEF_SYMBOL_WIDTH,
   parameter logic [SYMBOL_WIDTH:0] GF_POLY      = (SYMBOL_WIDTH + 1)'(DEF_GF_POLY)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_clr,
   input  logic                    i_en,
   input  logic                    i_first,
   input  logic [SYMBOL_WIDTH-1:0] i_data,
   output logic [SYMBOL_WIDTH-1:0] o_s1,
   output logic [SYMBOL_WIDTH-1:0] o_s2
);

   typedef logic [SYMBOL_WIDTH-1:0] sym_t;

   localparam gf_t POLY = gf_t'(GF_POLY);

   function automatic sym_t f_alpha(input sym_t a);
      return sym_t'(gf_mul_alpha(gf_t'(a), POLY, SYMBOL_WIDTH));
   endfunction

   sym_t r_s1;
   sym_t r_s2;
   sym_t w_s1_next;
   sym_t w_s2_next;

   // Next syndrome values; the first beat starts from zero instead of the old value
   always_comb begin
      w_s1_next = (i_first ? '0 : f_alpha(r_s1)) ^ i_data;
      w_s2_next = (i_first ? '0 : f_alpha(f_alpha(r_s2))) ^ i_data;
   end

   // Syndrome registers with clear and enable
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else if (i_clr) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else if (i_en) begin
         r_s1 <= w_s1_next;
         r_s2 <= w_s2_next;
      end
   end

   assign o_s1 = r_s1;
   assign o_s2 = r_s2;

endmodule

// File: rtl/rs_stream_decoder.sv
// Symbol-serial single-error Reed-Solomon decoder: buffers one codeword while
// accumulating syndromes, solves for locator/value in one cycle, then streams the
// corrected codeword out with per-codeword status flags.
module rs_stream_decoder
   import rs_stream_decoder_pkg::*;
#(
   parameter int unsigned           SYMBOL_WIDTH = DEF_SYMBOL_WIDTH,
   parameter int unsigned           N            = DEF_N,
   parameter logic [SYMBOL_WIDTH:0] GF_POLY      = (SYMBOL_WIDTH + 1)'(DEF_GF_POLY),
   parameter int unsigned           CNT_WIDTH    = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   rs_stream_decoder_if.slave   bus,
   output logic [CNT_WIDTH-1:0] corr_count
);

   typedef logic [SYMBOL_WIDTH-1:0] sym_t;

   localparam int unsigned       IDX_W    = $clog2(N);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);
   localparam gf_t               POLY     = gf_t'(GF_POLY);
   localparam sym_t              P_INIT   = sym_t'(gf_alpha_pow(N - 1, POLY, SYMBOL_WIDTH));

   function automatic sym_t f_alpha_inv(input sym_t a);
      return sym_t'(gf_mul_alpha_inv(gf_t'(a), POLY, SYMBOL_WIDTH));
   endfunction

   function automatic sym_t f_mul(input sym_t a, input sym_t b);
      return sym_t'(gf_mul(gf_t'(a), gf_t'(b), POLY, SYMBOL_WIDTH));
   endfunction

   function automatic sym_t f_div(input sym_t a, input sym_t b);
      return sym_t'(gf_div(gf_t'(a), gf_t'(b), POLY, SYMBOL_WIDTH));
   endfunction

   state_t              r_state;
   state_t              w_next_state;
   logic [IDX_W-1:0]    r_idx;
   sym_t                r_buf [N];
   sym_t                r_x;
   sym_t                r_y;
   sym_t                r_p;
   synd_class_t         r_cls;
   logic                r_hit;
   logic [CNT_WIDTH-1:0] r_corr_count;

   sym_t        w_s1;
   sym_t        w_s2;
   sym_t        w_x;
   sym_t        w_y;
   synd_class_t w_cls;
   logic        w_match;
   logic        w_in_hs;
   logic        w_out_hs;

   logic        w_in_ready;
   logic        w_out_valid;
   sym_t        w_out_data;
   logic        w_out_last;
   logic        w_out_corrected;
   logic        w_out_uncorr;

   assign w_in_hs  = bus.in_valid & w_in_ready;
   assign w_out_hs = w_out_valid & bus.out_ready;
   assign w_match  = (r_cls == CANDIDATE) && (r_p == r_x);

   rs_syndrome_acc #(
      .SYMBOL_WIDTH (SYMBOL_WIDTH),
      .GF_POLY      (GF_POLY)
   ) u_synd (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (r_state == IDLE),
      .i_en    (w_in_hs),
      .i_first (r_idx == IDX_LAST),
      .i_data  (bus.in_data),
      .o_s1    (w_s1),
      .o_s2    (w_s2)
   );

   // Locator, error value and syndrome class; division by zero is masked by the class
   always_comb begin
      w_x = f_div(w_s2, w_s1);
      w_y = f_div(f_mul(w_s1, w_s1), w_s2);
      if ((w_s1 == '0) && (w_s2 == '0))
         w_cls = CLEAN;
      else if ((w_s1 == '0) || (w_s2 == '0))
         w_cls = UNCORR;
      else
         w_cls = CANDIDATE;
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    w_next_state = COLLECT;
         COLLECT: if (w_in_hs && (r_idx == '0)) w_next_state = SOLVE;
         SOLVE:   w_next_state = EMIT;
         EMIT:    if (w_out_hs && (r_idx == '0)) w_next_state = COLLECT;
         default: w_next_state = IDLE;
      endcase
   end

   // Output decode; flags are qualified by the position-0 beat
   always_comb begin
      w_in_ready      = 1'b0;
      w_out_valid     = 1'b0;
      w_out_data      = '0;
      w_out_last      = 1'b0;
      w_out_corrected = 1'b0;
      w_out_uncorr    = 1'b0;
      case (r_state)
         COLLECT: w_in_ready = 1'b1;
         EMIT: begin
            w_out_valid     = 1'b1;
            w_out_data      = r_buf[r_idx] ^ (w_match ? r_y : '0);
            w_out_last      = (r_idx == '0);
            w_out_corrected = w_out_last & (r_hit | w_match);
            w_out_uncorr    = w_out_last &
                              ((r_cls == UNCORR) |
                               ((r_cls == CANDIDATE) & ~r_hit & ~w_match));
         end
         default: ;
      endcase
   end

   assign bus.in_ready          = w_in_ready;
   assign bus.out_valid         = w_out_valid;
   assign bus.out_data          = w_out_data;
   assign bus.out_last          = w_out_last;
   assign bus.out_corrected     = w_out_corrected;
   assign bus.out_uncorrectable = w_out_uncorr;
   assign corr_count            = r_corr_count;

   // Index, solver results, running locator, hit flag and corrected-codeword counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idx        <= '0;
         r_x          <= '0;
         r_y          <= '0;
         r_p          <= '0;
         r_cls        <= CLEAN;
         r_hit        <= 1'b0;
         r_corr_count <= '0;
      end else begin
         case (r_state)
            IDLE: r_idx <= IDX_LAST;
            COLLECT: begin
               if (w_in_hs)
                  r_idx <= (r_idx == '0) ? IDX_LAST : r_idx - IDX_W'(1);
            end
            SOLVE: begin
               r_x   <= w_x;
               r_y   <= w_y;
               r_cls <= w_cls;
               r_p   <= P_INIT;
               r_hit <= 1'b0;
            end
            EMIT: begin
               if (w_out_hs) begin
                  r_idx <= (r_idx == '0) ? IDX_LAST : r_idx - IDX_W'(1);
                  r_p   <= f_alpha_inv(r_p);
                  if (w_match)
                     r_hit <= 1'b1;
                  if (w_out_corrected && (r_corr_count != '1))
                     r_corr_count <= r_corr_count + CNT_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Codeword buffer, written in arrival order; contents need no reset
   always_ff @(posedge clk) begin
      if (w_in_hs)
         r_buf[r_idx] <= bus.in_data;
   end

endmodule
